// File: rtl/vmicro16_run_checker_if.sv
// Bundle between a vmicro16 regression environment and the run checker.
// The environment (master) drives run control, the SoC halt/GPIO observations
// and the expected results; the checker (slave) returns the SoC reset and the
// verdict of the run.
interface vmicro16_run_checker_if #(
  parameter int GPIO_WIDTH = 16,
  parameter int CHANNELS   = 1
);
  logic                           restart;
  logic                           halt;
  logic [CHANNELS*GPIO_WIDTH-1:0] gpio;
  logic [CHANNELS*GPIO_WIDTH-1:0] exp_val;
  logic [CHANNELS*GPIO_WIDTH-1:0] exp_mask;
  logic                           soc_reset;
  logic                           done;
  logic                           pass;
  logic                           fail;
  logic                           timeout;
  logic [CHANNELS-1:0]            mismatch;
  logic [31:0]                    cycles;

  modport master (
    output restart, halt, gpio, exp_val, exp_mask,
    input  soc_reset, done, pass, fail, timeout, mismatch, cycles
  );

  modport slave (
    input  restart, halt, gpio, exp_val, exp_mask,
    output soc_reset, done, pass, fail, timeout, mismatch, cycles
  );
endinterface

// File: rtl/vmicro16_run_checker.sv
// Run sequencer/checker for vmicro16 SoC regression.
// Holds the SoC in reset for RESET_CYCLES clocks, counts run cycles until the
// SoC halts or TIMEOUT run cycles elapse, then compares the captured GPIO
// channels against masked expected values. All outputs come from registers.
module vmicro16_run_checker #(
  parameter int GPIO_WIDTH   = 16,
  parameter int CHANNELS     = 1,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  vmicro16_run_checker_if.slave  bus
);

  localparam int              DW        = CHANNELS * GPIO_WIDTH;
  localparam int              RCW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0]  RC_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [31:0]     TIMEOUT_L = 32'(TIMEOUT);
  localparam logic [31:0]     CYC_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A channel fails when any compared bit differs; a zero mask never fails.
  function automatic logic [CHANNELS-1:0] compare_channels(
    input logic [DW-1:0] cap,
    input logic [DW-1:0] val,
    input logic [DW-1:0] mask
  );
    logic [CHANNELS-1:0] mis;
    mis = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      mis[i] = |((cap[i*GPIO_WIDTH +: GPIO_WIDTH] ^ val[i*GPIO_WIDTH +: GPIO_WIDTH])
                 & mask[i*GPIO_WIDTH +: GPIO_WIDTH]);
    end
    return mis;
  endfunction

  state_t              state_r,     state_n;
  logic [RCW-1:0]      rst_cnt_r,   rst_cnt_n;
  logic                soc_reset_r, soc_reset_n;
  logic                done_r,      done_n;
  logic                pass_r,      pass_n;
  logic                fail_r,      fail_n;
  logic                timeout_r,   timeout_n;
  logic [CHANNELS-1:0] mismatch_r,  mismatch_n;
  logic [31:0]         cycles_r,    cycles_n;
  logic [DW-1:0]       cap_r,       cap_n;
  logic [31:0]         cycles_inc_s;
  logic [CHANNELS-1:0] mis_s;

  // State and result registers; reset wins over every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_RESET;
      rst_cnt_r   <= {RCW{1'b0}};
      soc_reset_r <= 1'b1;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
      mismatch_r  <= {CHANNELS{1'b0}};
      cycles_r    <= 32'd0;
      cap_r       <= {DW{1'b0}};
    end else begin
      state_r     <= state_n;
      rst_cnt_r   <= rst_cnt_n;
      soc_reset_r <= soc_reset_n;
      done_r      <= done_n;
      pass_r      <= pass_n;
      fail_r      <= fail_n;
      timeout_r   <= timeout_n;
      mismatch_r  <= mismatch_n;
      cycles_r    <= cycles_n;
      cap_r       <= cap_n;
    end
  end

  // Next-state and next-result logic for the reset/run/check/done sequence.
  always_comb begin
    state_n      = state_r;
    rst_cnt_n    = rst_cnt_r;
    soc_reset_n  = soc_reset_r;
    done_n       = done_r;
    pass_n       = pass_r;
    fail_n       = fail_r;
    timeout_n    = timeout_r;
    mismatch_n   = mismatch_r;
    cycles_n     = cycles_r;
    cap_n        = cap_r;
    cycles_inc_s = (cycles_r == CYC_MAX) ? cycles_r : (cycles_r + 32'd1);
    mis_s        = compare_channels(cap_r, bus.exp_val, bus.exp_mask);

    case (state_r)
      S_RESET: begin
        soc_reset_n = 1'b1;
        if (rst_cnt_r == RC_LAST) begin
          state_n     = S_RUN;
          soc_reset_n = 1'b0;
          rst_cnt_n   = {RCW{1'b0}};
          cycles_n    = 32'd0;
        end else begin
          rst_cnt_n   = rst_cnt_r + RCW'(1);
        end
      end
      S_RUN: begin
        cycles_n = cycles_inc_s;
        // Halt takes priority over a timeout landing on the same edge.
        if (bus.halt && !soc_reset_r) begin
          cap_n   = bus.gpio;
          state_n = S_CHECK;
        end else if (cycles_inc_s >= TIMEOUT_L) begin
          state_n    = S_DONE;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          fail_n     = 1'b1;
          pass_n     = 1'b0;
          mismatch_n = {CHANNELS{1'b0}};
        end else begin
          state_n = S_RUN;
        end
      end
      S_CHECK: begin
        mismatch_n = mis_s;
        done_n     = 1'b1;
        pass_n     = ~|mis_s;
        fail_n     = |mis_s;
        state_n    = S_DONE;
      end
      S_DONE: begin
        if (bus.restart) begin
          state_n     = S_RESET;
          rst_cnt_n   = {RCW{1'b0}};
          soc_reset_n = 1'b1;
          done_n      = 1'b0;
          pass_n      = 1'b0;
          fail_n      = 1'b0;
          timeout_n   = 1'b0;
          mismatch_n  = {CHANNELS{1'b0}};
          cycles_n    = 32'd0;
          cap_n       = {DW{1'b0}};
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n     = S_RESET;
        rst_cnt_n   = {RCW{1'b0}};
        soc_reset_n = 1'b1;
      end
    endcase
  end

  assign bus.soc_reset = soc_reset_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.fail      = fail_r;
  assign bus.timeout   = timeout_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.cycles    = cycles_r;

endmodule
